lii_out_arbiter: RTL

- Shares one LII phy output channel between NOUT logic output streams produced by HLS kernels.
- Arbitrates round-robin at burst granularity and packs each selected beat into PW bits.
- Tags every beat with src/dst IDs and registers the output.
- Sits between kernel output streams and the phy out channel, mirroring the input-side unpack wrappers.

---
 rtl/lii_pkg.sv | 23 ++
 rtl/lii_out_arbiter_rr_pick.sv | 29 ++
 rtl/lii_out_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lii_pkg.sv
// Shared types and helpers for the LII phy output arbiter.
package lii_pkg;

    localparam int unsigned LII_ID_W = 8;
    localparam int unsigned LII_PW   = 64;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Sideband travelling with every packed beat on the phy channel.
    typedef struct packed {
        logic [LII_ID_W-1:0] src;
        logic [LII_ID_W-1:0] dst;
        logic                last;
    } lii_tag_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lii_out_arbiter_rr_pick.sv
// Combinational round-robin select: first requester at or after ptr, cyclically.
module rr_pick
    import lii_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned GW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [GW-1:0] grant,
    output logic          any_req
);

    logic [GW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = |req;
        for (int unsigned k = 0; k < N; k++) begin
            idx = GW'((32'(ptr) + (N - 1 - k)) % N);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/lii_out_arbiter.sv
// Round-robin burst arbiter sharing one LII phy output channel between NOUT kernel streams.
module lii_out_arbiter
    import lii_pkg::*;
#(
    parameter int unsigned          NOUT     = 4,
    parameter int unsigned          DW       = 8,
    parameter int unsigned          PW       = LII_PW,
    parameter int unsigned          MAXBURST = 4,
    parameter logic [LII_ID_W-1:0]  SRC_BASE = 8'h00
) (
    input  logic                            aclk,
    input  logic                            arstn,
    input  logic [NOUT*DW-1:0]              s_tdata,
    input  logic [NOUT-1:0]                 s_tvalid,
    output logic [NOUT-1:0]                 s_tready,
    input  logic [NOUT-1:0]                 s_tlast,
    input  logic [NOUT*LII_ID_W-1:0]        s_dst,
    output logic [PW-1:0]                   lii_out_p0_tdata,
    output logic                            lii_out_p0_tvalid,
    input  logic                            lii_out_p0_tready,
    output logic [LII_ID_W-1:0]             lii_out_p0_src,
    output logic [LII_ID_W-1:0]             lii_out_p0_dst,
    output logic                            lii_out_p0_tlast,
    output logic [clog2_min1(NOUT)-1:0]     grant_id,
    output logic                            busy
);

    localparam int unsigned   GW       = clog2_min1(NOUT);
    localparam int unsigned   CW       = clog2_min1(MAXBURST);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAXBURST - 1);
    localparam logic [GW-1:0] LAST_IDX = GW'(NOUT - 1);

    state_t                           state;
    state_t                           state_next;
    logic [GW-1:0]                    ptr;
    logic [GW-1:0]                    grant;
    logic [CW-1:0]                    beat_cnt;
    logic [GW-1:0]                    pick_grant;
    logic                             any_req;
    logic                             out_free;
    logic                             accept;
    logic                             burst_end;
    logic [NOUT-1:0][DW-1:0]          data_arr;
    logic [NOUT-1:0][LII_ID_W-1:0]    dst_arr;
    lii_tag_t                         tag;

    assign data_arr = s_tdata;
    assign dst_arr  = s_dst;
    assign out_free = !lii_out_p0_tvalid || lii_out_p0_tready;

    rr_pick #(.N(NOUT)) u_rr_pick (
        .req     (s_tvalid),
        .ptr     (ptr),
        .grant   (pick_grant),
        .any_req (any_req)
    );

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = SEND;
            SEND:    if (accept && burst_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Only the granted stream sees ready, and only when the output stage can take a beat.
    always_comb begin
        s_tready  = '0;
        accept    = 1'b0;
        burst_end = s_tlast[grant] || (beat_cnt == LAST_CNT);
        if (state == SEND) begin
            s_tready[grant] = out_free;
            accept          = s_tvalid[grant] && out_free;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            ptr      <= '0;
            grant    <= '0;
            beat_cnt <= '0;
        end else if (state == IDLE && any_req) begin
            grant    <= pick_grant;
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (burst_end) begin
                ptr <= (grant == LAST_IDX) ? '0 : grant + GW'(1);
            end
        end
    end

    // Single output stage: holds its beat until the phy takes it.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            lii_out_p0_tvalid <= 1'b0;
            lii_out_p0_tdata  <= '0;
            tag               <= '0;
        end else if (accept) begin
            lii_out_p0_tvalid <= 1'b1;
            lii_out_p0_tdata  <= PW'(data_arr[grant]);
            tag.src           <= SRC_BASE + LII_ID_W'(grant);
            tag.dst           <= dst_arr[grant];
            tag.last          <= burst_end;
        end else if (lii_out_p0_tready) begin
            lii_out_p0_tvalid <= 1'b0;
        end
    end

    assign lii_out_p0_src   = tag.src;
    assign lii_out_p0_dst   = tag.dst;
    assign lii_out_p0_tlast = tag.last;
    assign grant_id         = grant;
    assign busy             = (state == SEND);

endmodule
